// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and constants for the register-bank arbiter
// Contents: FSM state encoding, rw direction constants, default bank geometry.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational round-robin winner selector
// Ports:
//   eligible  in   NREQ  requesters that may be granted this cycle
//   last      in   2     index of the previous winner (search starts one past it)
//   winner    out  2     selected requester index (0 when valid is low)
//   valid     out  1     at least one requester was eligible
module shared_reg_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [1:0]      last,
  output logic [1:0]      winner,
  output logic            valid
);

  // Walk the ring starting just after the last winner; the first eligible
  // requester found wins. The last winner itself is visited last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && eligible[j] && (j == ((int'(last) + k) % NREQ))) begin
          valid  = 1'b1;
          winner = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin controller sharing a small register bank
// Ports:
//   clk       in   1           rising-edge clock
//   reset     in   1           synchronous active-high reset
//   req       in   NREQ        per-requester request, held until its ack
//   rw        in   NREQ        per-requester direction, 1 = write, 0 = read
//   addr      in   NREQ*AW     flattened word addresses, requester i at [i*AW +: AW]
//   wdata     in   NREQ*WIDTH  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   rdata     out  WIDTH       read data, meaningful while a read's ack is high; holds otherwise
//   ack       out  NREQ        one-hot single-cycle completion pulse
//   busy      out  1           access in progress
//   grant_id  out  2           current or most recent winner
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       rw,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  state_t            state, next_state;
  logic [1:0]        last_winner;
  logic [NREQ-1:0]   eligible;
  logic [1:0]        pick_id;
  logic              pick_valid;
  logic [WIDTH-1:0]  bank [DEPTH];

  logic              cur_rw;
  logic [AW-1:0]     cur_addr;
  logic [WIDTH-1:0]  cur_wdata;
  logic [NREQ-1:0]   grant_onehot;

  // A requester whose ack is high this cycle has not yet had a chance to
  // drop req, so it must not be regranted on this edge.
  assign eligible = req & ~ack;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .eligible (eligible),
    .last     (last_winner),
    .winner   (pick_id),
    .valid    (pick_valid)
  );

  // Route the granted requester's fields onto the shared access path.
  always_comb begin
    cur_rw       = RW_READ;
    cur_addr     = '0;
    cur_wdata    = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 2'(i)) begin
        cur_rw          = rw[i];
        cur_addr        = addr[i*AW +: AW];
        cur_wdata       = wdata[i*WIDTH +: WIDTH];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (pick_valid) next_state = ST_BUSY;
      ST_BUSY: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
      rdata       <= '0;
      ack         <= '0;
      grant_id    <= '0;
      // Pointing at the highest index makes requester 0 first in line.
      last_winner <= 2'(NREQ - 1);
    end else begin
      ack <= '0;
      if (state == ST_IDLE && pick_valid) begin
        grant_id <= pick_id;
      end
      if (state == ST_BUSY) begin
        if (cur_rw == RW_WRITE) begin
          bank[cur_addr] <= cur_wdata;
        end else begin
          rdata <= bank[cur_addr];
        end
        ack         <= grant_onehot;
        last_winner <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  rw;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [4];

  shared_reg_arbiter #(
    .NREQ  (2),
    .WIDTH (16),
    .DEPTH (4),
    .AW    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_grant", 32'(grant_id), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0;
  endtask

  task automatic drive(input int id, input bit w, input logic [1:0] a, input logic [15:0] d);
    rw[id]              = w;
    addr[id*2 +: 2]     = a;
    wdata[id*16 +: 16]  = d;
    req[id]             = 1'b1;
  endtask

  // Expected results are pushed in the order the bench expects grants.
  task automatic push(input int id, input bit w, input logic [1:0] a, input logic [15:0] d,
                      input int cyc);
    exp_t e;
    e.id  = id;
    e.rd  = !w;
    e.cyc = cyc;
    if (w) begin
      model[a] = d;
      e.data   = d;
    end else begin
      e.data = model[a];
    end
    sb.push_back(e);
  endtask

  // Observe n acks. Requesters drop req one negedge after their ack
  // (a registered client), unless hold is set, in which case req stays
  // high until the final ack.
  task automatic run(input int n, input bit hold);
    int         cyc      = 0;
    int         got      = 0;
    int         busy_cnt = 0;
    logic [1:0] pend     = '0;
    exp_t       e;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req  = req & ~pend;
      pend = '0;
      if (busy) busy_cnt++;
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          e = sb.pop_front();
          check("ack_onehot", 32'(ack), 32'(2'b01 << e.id));
          check("ack_grant_id", 32'(grant_id), 32'(e.id));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.rd) check("read_data", 32'(rdata), 32'(e.data));
        end
        got++;
        if (hold) begin
          if (got == n) req = '0;
        end else begin
          pend = ack;
        end
      end
    end
    check("ack_count", 32'(got), 32'(n));
    check("busy_cycles", 32'(busy_cnt), 32'(n));
    @(negedge clk);
    req = req & ~pend;
    check("post_no_ack", 32'(ack), 32'h0);
    check("post_no_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    rw    = '0;
    addr  = '0;
    wdata = '0;

    // 1: reset state, then a read of addr 3 returns zero two cycles after req
    do_reset();
    drive(0, 1'b0, 2'd3, 16'h0);
    push(0, 1'b0, 2'd3, 16'h0, 2);
    run(1, 1'b0);

    // 2: write then read back
    drive(0, 1'b1, 2'd2, 16'h6FA7);
    push(0, 1'b1, 2'd2, 16'h6FA7, 2);
    run(1, 1'b0);
    drive(0, 1'b0, 2'd2, 16'h0);
    push(0, 1'b0, 2'd2, 16'h0, 2);
    run(1, 1'b0);

    // 3: contention, requester 0 first after reset, acks two cycles apart
    do_reset();
    drive(0, 1'b1, 2'd1, 16'h1111);
    drive(1, 1'b1, 2'd1, 16'h2222);
    push(0, 1'b1, 2'd1, 16'h1111, 2);
    push(1, 1'b1, 2'd1, 16'h2222, 4);
    run(2, 1'b0);
    drive(0, 1'b0, 2'd1, 16'h0);
    push(0, 1'b0, 2'd1, 16'h0, 2);
    run(1, 1'b0);

    // 4: continuous requests alternate 0,1,0,1,...
    do_reset();
    drive(0, 1'b0, 2'd2, 16'h0);
    drive(1, 1'b1, 2'd2, 16'hA5A5);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push(0, 1'b0, 2'd2, 16'h0, 2 * (k + 1));
      else            push(1, 1'b1, 2'd2, 16'hA5A5, 2 * (k + 1));
    end
    run(8, 1'b1);

    // 5: reset during BUSY aborts the write and clears the bank
    drive(0, 1'b1, 2'd0, 16'h1234);
    push(0, 1'b1, 2'd0, 16'h1234, 2);
    run(1, 1'b0);
    drive(1, 1'b1, 2'd0, 16'hBEEF);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h1);
    check("abort_grant", 32'(grant_id), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_ack", 32'(ack), 32'h0);
    check("abort_idle", 32'(busy), 32'h0);
    req   = '0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0;
    drive(0, 1'b0, 2'd0, 16'h0);
    push(0, 1'b0, 2'd0, 16'h0, 2);
    run(1, 1'b0);

    // 6: idle stability, rdata holds the last read value
    drive(1, 1'b1, 2'd3, 16'h00FF);
    push(1, 1'b1, 2'd3, 16'h00FF, 2);
    run(1, 1'b0);
    drive(0, 1'b0, 2'd3, 16'h0);
    push(0, 1'b0, 2'd3, 16'h0, 2);
    run(1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_ack", 32'(ack), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_rdata", 32'(rdata), 32'h00FF);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
